// File: rtl/dsram_resp.sv
// Single-port word SRAM responder: programmable wait states, byte-lane writes,
// registered read data with a one-cycle valid pulse and a sticky bad-wen flag.
module dsram_resp #(
  parameter int AW   = 10,
  parameter int WAIT = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        rvalid,
  output logic        stallreq,
  output logic        wen_err
);

  localparam int         DEPTH    = 1 << AW;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  logic [3:0]    cnt_reg;
  logic [3:0]    cnt_next;
  logic [31:0]   rdata_reg;
  logic          rvalid_reg;
  logic          wen_err_reg;

  logic [AW-1:0] word_idx;
  logic [31:0]   ram_word;
  logic          perform;
  logic          wen_legal;
  logic          rd_fire;
  logic          wr_fire;
  logic          err_fire;
  logic          unused_addr;

  // Upper and byte-offset address bits alias onto the same word.
  assign word_idx    = data_sram_addr[AW+1:2];
  assign unused_addr = ^{data_sram_addr[31:AW+2], data_sram_addr[1:0]};

  assign perform  = data_sram_en && (cnt_reg == WAIT_CNT);
  assign stallreq = data_sram_en && (cnt_reg != WAIT_CNT);

  always_comb begin
    wen_legal = 1'b0;
    case (data_sram_wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: wen_legal = 1'b1;
      default:                   wen_legal = 1'b0;
    endcase
  end

  assign rd_fire  = perform && (data_sram_wen == 4'b0000);
  assign wr_fire  = perform && wen_legal;
  assign err_fire = perform && (data_sram_wen != 4'b0000) && !wen_legal;

  // Dropping en abandons a partially held request.
  always_comb begin
    cnt_next = cnt_reg;
    if (!data_sram_en || perform) begin
      cnt_next = 4'd0;
    end else begin
      cnt_next = cnt_reg + 4'd1;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] ram [DEPTH];

    always_ff @(posedge clk) begin
      if (wr_fire && data_sram_wen[gi]) begin
        ram[word_idx] <= data_sram_wdata[8*gi +: 8];
      end
    end

    assign ram_word[8*gi +: 8] = ram[word_idx];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_reg     <= 4'd0;
      rdata_reg   <= 32'd0;
      rvalid_reg  <= 1'b0;
      wen_err_reg <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      rvalid_reg <= rd_fire;
      if (rd_fire) begin
        rdata_reg <= ram_word;
      end
      if (err_fire) begin
        wen_err_reg <= 1'b1;
      end
    end
  end

  assign data_sram_rdata = rdata_reg;
  assign rvalid          = rvalid_reg;
  assign wen_err         = wen_err_reg;

endmodule

// File: doc/dsram_resp.md
DSRAM_RESP -- requirements
Module: dsram_resp

Interface
REQ-001 SHALL have parameter AW, default 10, word-address width (memory depth 2^AW 32-bit words).
REQ-002 SHALL have parameter WAIT, default 0, extra wait cycles per access, legal range 0..15.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port data_sram_en  input  1  access request, held by initiator until stallreq low.
REQ-006 SHALL have port data_sram_wen  input  4  byte-lane write enables, lane i = bits [8i+7:8i]; 0000 = read.
REQ-007 SHALL have port data_sram_addr  input  32  byte address.
REQ-008 SHALL have port data_sram_wdata  input  32  write data, lane-replicated by initiator.
REQ-009 SHALL have port data_sram_rdata  output  32  read data word, registered.
REQ-010 SHALL have port rvalid  output  1  one-cycle pulse, rdata updated this cycle.
REQ-011 SHALL have port stallreq  output  1  initiator must hold request (Stop=1).
REQ-012 SHALL have port wen_err  output  1  sticky illegal-write-enable flag.

Function
REQ-013 Word index SHALL be addr[AW+1:2]; addr[31:AW+2] and addr[1:0] ignored (aliasing, no fault).
REQ-014 Hold counter cnt (4 bits) SHALL count cycles current request has been held.
REQ-015 stallreq SHALL be combinational: data_sram_en AND (cnt != WAIT); with WAIT=0 stallreq is constant 0.
REQ-016 Edge with en=1, cnt!=WAIT: cnt <= cnt+1, no memory side effect.
REQ-017 Edge with en=1, cnt==WAIT ("perform edge"): access executes, cnt <= 0.
REQ-018 Edge with en=0: cnt <= 0; partially-held request abandoned, no side effect.
REQ-019 Write at perform edge: only lanes with wen[i]=1 updated; other lanes retain value.
REQ-020 Legal wen: 0000, 0001, 0010, 0100, 1000, 0011, 1100, 1111; any other nonzero pattern SHALL suppress the write and set wen_err at that perform edge.
REQ-021 wen_err SHALL stay 1 until resetn asserted.
REQ-022 Read at perform edge: data_sram_rdata <= mem[index]; rvalid = 1 for the following cycle only.
REQ-023 Read latency SHALL be WAIT+1 cycles from first cycle en presented to rdata valid.
REQ-024 data_sram_rdata SHALL hold last read value through writes and idle cycles.
REQ-025 Back-to-back requests (en continuously 1, new addr after each perform edge) SHALL each complete in WAIT+1 cycles without gaps; with WAIT=0 one access per cycle.
REQ-026 Read of word written at immediately preceding perform edge SHALL return new data.
REQ-027 Same-edge read/write conflict does not exist (single port, one access per perform edge).
REQ-028 Memory contents SHALL NOT be initialised by reset; uninitialised reads are X in simulation.

Reset
REQ-029 resetn=0 SHALL asynchronously force cnt=0, data_sram_rdata=0, rvalid=0, wen_err=0; stallreq then follows REQ-015.
REQ-030 Reset during a held request SHALL abandon it; no write to memory, no rvalid after deassertion.
REQ-031 Memory array SHALL NOT be altered by reset.

Verification
REQ-032 WAIT=0: write addr 0x10 wen 1111 wdata 0xDEADBEEF, next cycle read 0x10 -> cycle after: rdata 0xDEADBEEF, rvalid 1 for one cycle, stallreq 0 throughout.
REQ-033 WAIT=0: after REQ-032, write 0x12 wen 1100 wdata 0x12341234, read 0x10 -> rdata 0x1234BEEF; write 0x13 wen 1000 wdata 0x55555555, read -> 0x5534BEEF.
REQ-034 WAIT=3: read 0x20 held -> stallreq 1 for 3 cycles, 0 on 4th; rvalid in 5th cycle; second held read follows with identical timing.
REQ-035 WAIT=3: write held 2 cycles then en dropped -> memory at address unchanged on later read, cnt returns 0, no wen_err.
REQ-036 Write wen 0101 to 0x30 holding 0x11223344 -> wen_err 1 and stays 1, readback 0x11223344; resetn pulse -> wen_err 0.
REQ-037 WAIT=2: resetn asserted mid-hold of write -> rdata 0, rvalid 0, stallreq re-evaluates from cnt 0, target word unchanged.
